// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared lane geometry, FSM encoding and lane-offset helper for
//               the 4-lane TDM demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Bit offset of a lane inside the packed frame word.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_lane_counter.sv
`default_nettype none
// ============================================================================
// Module      : tdm_lane_counter
// Description : 2-bit lane counter with enable, load-to-1 and last-lane flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_lane_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_one,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);

    logic [SEL_W-1:0] cnt_d;
    logic [SEL_W-1:0] cnt_q;

    // A restart must always land on lane 1, so load beats the increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load_one) begin
            cnt_d = SEL_W'(1);
        end else if (en) begin
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == SEL_W'(LANES - 1));

endmodule
`default_nettype wire

// File: rtl/tdm_demux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_4x1
// Description : Registered 1-to-4 TDM demultiplexer; collects one framed lane
//               sequence into a shadow buffer and publishes it atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_4x1
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       din,
    input  logic                    din_valid,
    input  logic                    frame_start,
    output logic [LANES*DATA_W-1:0] y,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic [SEL_W-1:0]        sel
);

    state_t                    state_d, state_q;
    logic [DATA_W-1:0]         shadow_d [LANES];
    logic [DATA_W-1:0]         shadow_q [LANES];
    logic [LANES*DATA_W-1:0]   y_d, y_q;
    logic                      frame_valid_d, frame_valid_q;
    logic                      frame_err_d, frame_err_q;

    logic                      w_cnt_en;
    logic                      w_cnt_load;
    logic [SEL_W-1:0]          w_sel;
    logic                      w_last;

    tdm_lane_counter u_lane_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (w_cnt_en),
        .load_one (w_cnt_load),
        .cnt      (w_sel),
        .last     (w_last)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        w_cnt_en      = 1'b0;
        w_cnt_load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Samples without a frame marker are stray and dropped quietly.
                if (din_valid && frame_start) begin
                    shadow_d[0] = din;
                    w_cnt_load  = 1'b1;
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (din_valid && frame_start) begin
                    // Early restart: old partial frame is abandoned, y untouched.
                    for (int k = 1; k < LANES; k++) begin
                        shadow_d[k] = '0;
                    end
                    shadow_d[0] = din;
                    frame_err_d = 1'b1;
                    w_cnt_load  = 1'b1;
                end else if (din_valid) begin
                    shadow_d[w_sel] = din;
                    w_cnt_en        = 1'b1;
                    if (w_last) begin
                        for (int k = 0; k < LANES - 1; k++) begin
                            y_d[lane_lsb(k, DATA_W) +: DATA_W] = shadow_q[k];
                        end
                        y_d[lane_lsb(LANES - 1, DATA_W) +: DATA_W] = din;
                        frame_valid_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            for (int k = 0; k < LANES; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign y           = y_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign sel         = w_sel;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_4x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux_4x1
// Description : Scoreboard bench for tdm_demux_4x1 with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_4x1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] y;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  sel;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_y_q [$];
    int          exp_err_cnt = 0;
    int          seen_err_cnt = 0;
    logic [31:0] last_pub_y = '0;

    tdm_demux_4x1 #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .y           (y),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .sel         (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT pulses.
    always @(negedge clk) begin
        if (rst) begin
            last_pub_y <= '0;
        end else begin
            if (frame_valid && frame_err) begin
                check("pulse_overlap", 32'(frame_valid & frame_err), 32'd0);
            end
            if (frame_valid) begin
                if (exp_y_q.size() == 0) begin
                    check("unexpected_frame_valid", y, 32'hxxxxxxxx);
                end else begin
                    check("frame_y", y, exp_y_q.pop_front());
                end
                last_pub_y <= y;
            end
            if (frame_err) begin
                seen_err_cnt++;
                check("err_expected", 32'(seen_err_cnt <= exp_err_cnt), 32'd1);
                check("y_held_on_err", y, last_pub_y);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic fs, input logic [1:0] exp_sel);
        @(negedge clk);
        din         = d;
        din_valid   = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        check("sel", 32'(sel), 32'(exp_sel));
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, 32'h0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Invalid cycles must not move anything, even with frame_start high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din         = 8'(8'hE0 + i);
            frame_start = 1'b1;
            din_valid   = 1'b0;
            @(posedge clk);
            #1;
            check("gap_sel", 32'(sel), 32'd0);
            check("gap_y", y, 32'h0);
        end
        frame_start = 1'b0;

        // Single back-to-back frame.
        send(8'hA5, 1'b1, 2'd1);
        send(8'h3C, 1'b0, 2'd2);
        send(8'h0F, 1'b0, 2'd3);
        exp_y_q.push_back(32'hF00F3CA5);
        send(8'hF0, 1'b0, 2'd0);
        gap(2);

        // Gapped frame followed immediately by another.
        send(8'h11, 1'b1, 2'd1);
        send(8'h22, 1'b0, 2'd2);
        gap(2);
        send(8'h33, 1'b0, 2'd3);
        gap(2);
        exp_y_q.push_back(32'h44332211);
        send(8'h44, 1'b0, 2'd0);
        send(8'h55, 1'b1, 2'd1);
        send(8'h66, 1'b0, 2'd2);
        send(8'h77, 1'b0, 2'd3);
        exp_y_q.push_back(32'h88776655);
        send(8'h88, 1'b0, 2'd0);
        gap(2);

        // Early restart.
        send(8'h01, 1'b1, 2'd1);
        send(8'h02, 1'b0, 2'd2);
        exp_err_cnt++;
        send(8'h09, 1'b1, 2'd1);
        send(8'h0A, 1'b0, 2'd2);
        send(8'h0B, 1'b0, 2'd3);
        exp_y_q.push_back(32'h0C0B0A09);
        send(8'h0C, 1'b0, 2'd0);
        gap(2);
        check("restart_y", y, 32'h0C0B0A09);

        // Hunt: stray samples in IDLE are dropped.
        send(8'hDE, 1'b0, 2'd0);
        send(8'hAD, 1'b0, 2'd0);
        send(8'hBE, 1'b0, 2'd0);
        send(8'h5A, 1'b1, 2'd1);
        send(8'h6B, 1'b0, 2'd2);
        send(8'h7C, 1'b0, 2'd3);
        exp_y_q.push_back(32'h8D7C6B5A);
        send(8'h8D, 1'b0, 2'd0);
        gap(2);

        // Reset mid-frame discards the partial frame.
        send(8'hC1, 1'b1, 2'd1);
        send(8'hC2, 1'b0, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_y", y, 32'h0);
        check("midrst_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hC3, 1'b0, 2'd0);
        send(8'h21, 1'b1, 2'd1);
        send(8'h43, 1'b0, 2'd2);
        send(8'h65, 1'b0, 2'd3);
        check("midrst_y_hold", y, 32'h0);
        exp_y_q.push_back(32'h87654321);
        send(8'h87, 1'b0, 2'd0);
        gap(3);
        check("final_y", y, 32'h87654321);

        check("scoreboard_empty", 32'(exp_y_q.size()), 32'd0);
        check("err_count", 32'(seen_err_cnt), 32'(exp_err_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
